// File: rtl/bist_pkg.sv
// Shared definitions for the BILBO self-test sequencer: the chain mode encodings
// ({b1,b2}), the FSM state encoding and the state-to-mode mapping.
package bist_pkg;

  localparam logic [1:0] BILBO_NORMAL = 2'b10;  // d = data
  localparam logic [1:0] BILBO_SIG    = 2'b11;  // d = data ^ tdata
  localparam logic [1:0] BILBO_SHIFT  = 2'b01;  // d = tdata
  localparam logic [1:0] BILBO_CLEAR  = 2'b00;  // d = 0

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSeed,
    StRun,
    StUnload,
    StDone
  } bist_state_e;

  function automatic logic [1:0] state_mode(bist_state_e st);
    case (st)
      StClear:         return BILBO_CLEAR;
      StSeed, StUnload: return BILBO_SHIFT;
      StRun:           return BILBO_SIG;
      default:         return BILBO_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/bist_down_cnt.sv
// Loadable down-counter with terminal-count flag; holds at zero rather than wrapping.
module bist_down_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] count,
  output logic             tc
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '0);

endmodule

// File: rtl/bilbo_bist_ctrl.sv
// BILBO chain self-test sequencer: clear, optional seed scan-in, signature run, unload+compare.
// Define BILBO_BIST_SEED_EN to include the SEED scan-in phase.
module bilbo_bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned           CHAIN_LEN = 8,
  parameter int unsigned           PATTERNS  = 16,
  parameter logic [CHAIN_LEN-1:0]  SEED      = 8'h01,
  parameter logic [CHAIN_LEN-1:0]  SIGNATURE = 8'hA5
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         start,
  output logic                         bilbo_b1,
  output logic                         bilbo_b2,
  output logic                         scan_tdata,
  input  logic                         scan_tail,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(CHAIN_LEN)-1:0] fail_idx
);

  localparam int unsigned MaxLen = (CHAIN_LEN > PATTERNS) ? CHAIN_LEN : PATTERNS;
  localparam int unsigned CntW   = $clog2(MaxLen) + 1;
  localparam int unsigned IdxW   = $clog2(CHAIN_LEN);

  bist_state_e         state_q, state_d;
  logic [1:0]          mode_q;
  logic                busy_q, done_q, pass_q, miss_q;
  logic [IdxW-1:0]     fail_idx_q;

  logic                cnt_load, tc;
  logic [CntW-1:0]     cnt_val, cnt;
  logic [CHAIN_LEN-1:0] sel;
  logic                seed_bit, sig_bit, mismatch;

  bist_down_cnt #(
    .Width (CntW)
  ) u_cnt (
    .clock    (clock),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .count    (cnt),
    .tc       (tc)
  );

  // In SEED and UNLOAD the counter value equals the chain bit position being handled.
  assign sel      = {{(CHAIN_LEN-1){1'b0}}, 1'b1} << cnt;
  assign seed_bit = |(SEED & sel);
  assign sig_bit  = |(SIGNATURE & sel);
  assign mismatch = (state_q == StUnload) && (scan_tail != sig_bit);

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StClear;
          cnt_load = 1'b1;
        end
      end
      StClear: begin
        cnt_load = 1'b1;
`ifdef BILBO_BIST_SEED_EN
        state_d  = StSeed;
        cnt_val  = CntW'(CHAIN_LEN - 1);
`else
        state_d  = StRun;
        cnt_val  = CntW'(PATTERNS - 1);
`endif
      end
      StSeed: begin
        if (tc) begin
          state_d  = StRun;
          cnt_load = 1'b1;
          cnt_val  = CntW'(PATTERNS - 1);
        end
      end
      StRun: begin
        if (tc) begin
          state_d  = StUnload;
          cnt_load = 1'b1;
          cnt_val  = CntW'(CHAIN_LEN - 1);
        end
      end
      StUnload: begin
        if (tc) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // RUN feeds the tail straight back to the head, so tdata is combinational on the state.
  always_comb begin
    scan_tdata = 1'b0;
    case (state_q)
      StSeed:  scan_tdata = seed_bit;
      StRun:   scan_tdata = scan_tail;
      default: scan_tdata = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= BILBO_NORMAL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      miss_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= state_mode(state_d);
      busy_q  <= !(state_d inside {StIdle, StDone});
      done_q  <= (state_d == StDone);
      if (state_d == StClear) begin
        pass_q     <= 1'b0;
        miss_q     <= 1'b0;
        fail_idx_q <= '0;
      end else if (mismatch && !miss_q) begin
        miss_q     <= 1'b1;
        fail_idx_q <= IdxW'(cnt);
      end
      if (state_q == StUnload && state_d == StDone) begin
        pass_q <= !(miss_q || mismatch);
      end
    end
  end

  assign bilbo_b1 = mode_q[1];
  assign bilbo_b2 = mode_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_bilbo_bist_ctrl.sv
// Directed bench for bilbo_bist_ctrl with a behavioural 8-cell BILBO chain model.
module tb_bilbo_bist_ctrl;

  localparam int N   = 8;
  localparam int PAT = 16;
`ifdef BILBO_BIST_SEED_EN
  localparam int         SL     = 8;
  localparam logic [7:0] CHAIN0 = 8'h01;
`else
  localparam int         SL     = 0;
  localparam logic [7:0] CHAIN0 = 8'h00;
`endif
  localparam int TOT = 1 + SL + PAT + N;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       bilbo_b1, bilbo_b2, scan_tdata, scan_tail, busy, done, pass;
  logic [2:0] fail_idx;

  logic [7:0] chain      = 8'h00;
  logic [7:0] sig_inject = 8'h00;
  logic       load_sig   = 1'b0;

  int total = 0;
  int bad   = 0;

  bilbo_bist_ctrl #(
    .CHAIN_LEN (N),
    .PATTERNS  (PAT),
    .SEED      (8'h01),
    .SIGNATURE (8'hA5)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .bilbo_b1   (bilbo_b1),
    .bilbo_b2   (bilbo_b2),
    .scan_tdata (scan_tdata),
    .scan_tail  (scan_tail),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_idx   (fail_idx)
  );

  always #5 clock = ~clock;

  assign scan_tail = chain[7];

  // Chain model; parallel data is a fixed 8'h3C during signature mode.
  always_ff @(posedge clock) begin
    if (load_sig) begin
      chain <= sig_inject;
    end else begin
      case ({bilbo_b1, bilbo_b2})
        2'b00:   chain <= 8'h00;
        2'b01:   chain <= {chain[6:0], scan_tdata};
        2'b11:   chain <= {chain[6:0], scan_tdata} ^ 8'h3C;
        default: chain <= chain;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_mode(input int lat);
    if (lat < 1) return 2'b00;
    else if (lat < 1 + SL) return 2'b01;
    else if (lat < 1 + SL + PAT) return 2'b11;
    else if (lat < TOT) return 2'b01;
    else return 2'b10;
  endfunction

  // Call at the falling edge right after the edge that sampled start.
  task automatic run_body(input logic [7:0] sig, input int rst_at, input int pulse_at,
                          input bit hold, input bit exp_pass, input logic [2:0] exp_idx);
    int lat;
    bit fin;
    lat        = 0;
    fin        = 1'b0;
    sig_inject = sig;
    while (!fin && lat <= TOT + 5) begin
      if (lat == rst_at) begin
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        check("rst_mode", 32'({bilbo_b1, bilbo_b2}), 32'(2'b10));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        return;
      end
      check("mode", 32'({bilbo_b1, bilbo_b2}), 32'(exp_mode(lat)));
      check("busy", 32'(busy), 32'(lat < TOT));
      if (lat >= 1 && lat < 1 + SL) check("seed_tdata", 32'(scan_tdata), 32'(lat == SL));
      if (lat == 1 + SL) check("chain_init", 32'(chain), 32'(CHAIN0));
      if (lat >= 1 + SL + PAT && lat < TOT) check("unload_tdata", 32'(scan_tdata), 32'(0));
      if (done) begin
        check("latency", 32'(lat), 32'(TOT));
        check("pass", 32'(pass), 32'(exp_pass));
        if (!exp_pass) check("fail_idx", 32'(fail_idx), 32'(exp_idx));
        fin = 1'b1;
      end else begin
        load_sig = (lat == SL + PAT);
        start    = hold || (lat == pulse_at);
        @(posedge clock);
        @(negedge clock);
        lat++;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $error("FAIL done_timeout: got done=%0b expected done=1 within %0d cycles", done, TOT + 5);
    end
    load_sig = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  task automatic kick(input bit hold);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = hold;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_mode", 32'({bilbo_b1, bilbo_b2}), 32'(2'b10));
    check("reset_tdata", 32'(scan_tdata), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_pass", 32'(pass), 32'(0));
    check("reset_fail_idx", 32'(fail_idx), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("idle_mode", 32'({bilbo_b1, bilbo_b2}), 32'(2'b10));
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_done", 32'(done), 32'(0));
    end

    // Good signature.
    kick(1'b0);
    run_body(8'hA5, -1, -1, 1'b0, 1'b1, 3'd0);

    // Bit 5 flipped; start pulsed mid-UNLOAD must be ignored.
    kick(1'b0);
    run_body(8'h85, -1, 1 + SL + PAT + 3, 1'b0, 1'b0, 3'd5);
    @(posedge clock);
    @(negedge clock);
    check("held_done", 32'(done), 32'(1));
    check("held_pass", 32'(pass), 32'(0));
    check("held_fail_idx", 32'(fail_idx), 32'(5));

    // Reset during RUN cycle 7, then a full-length run.
    kick(1'b0);
    run_body(8'hA5, 1 + SL + 7, -1, 1'b0, 1'b1, 3'd0);
    @(posedge clock);
    @(negedge clock);
    check("post_rst_busy", 32'(busy), 32'(0));
    check("post_rst_mode", 32'({bilbo_b1, bilbo_b2}), 32'(2'b10));
    kick(1'b0);
    run_body(8'hA5, -1, -1, 1'b0, 1'b1, 3'd0);

    // Start held through DONE: done lasts one cycle, next run begins in CLEAR.
    kick(1'b1);
    run_body(8'hA5, -1, -1, 1'b1, 1'b1, 3'd0);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("restart_done", 32'(done), 32'(0));
    run_body(8'h85, -1, -1, 1'b0, 1'b0, 3'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
